// File: rtl/ex_mem_if.sv
// EX/MEM boundary bundle: upstream handshake, downstream handshake, flush and forwarding lookup.
// The slave modport is the pipeline register; the master modport is the surrounding EX/MEM/hazard logic.
interface ex_mem_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int OP_W   = 2
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] write_data_i;
    logic [OP_W-1:0]   mem_op_i;
    logic [DATA_W-1:0] mem_addr_i;
    logic              write_reg_i;
    logic [REG_AW-1:0] write_reg_addr_i;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] write_data_o;
    logic [OP_W-1:0]   mem_op_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic              write_reg_o;
    logic [REG_AW-1:0] write_reg_addr_o;
    logic [REG_AW-1:0] fwd_query_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    modport slave (
        input  flush, in_valid, write_data_i, mem_op_i, mem_addr_i, write_reg_i,
               write_reg_addr_i, out_ready, fwd_query_addr,
        output in_ready, out_valid, write_data_o, mem_op_o, mem_addr_o, write_reg_o,
               write_reg_addr_o, fwd_hit, fwd_data
    );

    modport master (
        output flush, in_valid, write_data_i, mem_op_i, mem_addr_i, write_reg_i,
               write_reg_addr_i, out_ready, fwd_query_addr,
        input  in_ready, out_valid, write_data_o, mem_op_o, mem_addr_o, write_reg_o,
               write_reg_addr_o, fwd_hit, fwd_data
    );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer, flush,
// NOP bubbles on the output when empty, and a forwarding lookup over the held entries.
module ex_mem_pipe #(
    parameter int              DATA_W     = 16,
    parameter int              REG_AW     = 4,
    parameter int              OP_W       = 2,
    parameter logic [OP_W-1:0] MEM_NOP_OP = '0
) (
    input logic   clk,
    input logic   rst,
    ex_mem_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] write_data;
        logic [OP_W-1:0]   mem_op;
        logic [DATA_W-1:0] mem_addr;
        logic              write_reg;
        logic [REG_AW-1:0] write_reg_addr;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;
    entry_t head_p0, skid_p1, in_entry;
    logic   in_ready_q;
    logic   vld_p0, vld_p1;
    logic   accept, retire;
    logic   load_head_in, load_head_skid, load_skid_in;
    logic   match_s, match_h;

    function automatic entry_t nop_entry();
        entry_t e;
        e        = '0;
        e.mem_op = MEM_NOP_OP;
        return e;
    endfunction

    always_comb begin
        in_entry.write_data     = bus.write_data_i;
        in_entry.mem_op         = bus.mem_op_i;
        in_entry.mem_addr       = bus.mem_addr_i;
        in_entry.write_reg      = bus.write_reg_i;
        in_entry.write_reg_addr = bus.write_reg_addr_i;
    end

    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
                if (retire && !accept)      state_nxt = EMPTY;
                else if (!retire && accept) state_nxt = FULL;
            end
            FULL:    if (retire) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
        if (bus.flush) state_nxt = EMPTY;
    end

    always_comb begin
        vld_p0         = (state != EMPTY);
        vld_p1         = (state == FULL);
        accept         = bus.in_valid && in_ready_q;
        retire         = vld_p0 && bus.out_ready;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (!bus.flush) begin
            load_head_in   = accept && ((state == EMPTY) || ((state == ONE) && retire));
            load_head_skid = (state == FULL) && retire;
            load_skid_in   = (state == ONE) && !retire && accept;
        end
    end

    // Stage boundary: head (p0) feeds MEM, skid (p1) absorbs one entry of back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_p0 <= nop_entry();
            skid_p1 <= nop_entry();
        end else begin
            if (load_head_in)        head_p0 <= in_entry;
            else if (load_head_skid) head_p0 <= skid_p1;
            if (load_skid_in)        skid_p1 <= in_entry;
        end
    end

    always_comb begin
        entry_t o;
        o                    = vld_p0 ? head_p0 : nop_entry();
        bus.in_ready         = in_ready_q;
        bus.out_valid        = vld_p0;
        bus.write_data_o     = o.write_data;
        bus.mem_op_o         = o.mem_op;
        bus.mem_addr_o       = o.mem_addr;
        bus.write_reg_o      = o.write_reg;
        bus.write_reg_addr_o = o.write_reg_addr;
    end

    // Skid holds the younger entry, so its match wins.
    always_comb begin
        match_s = vld_p1 && skid_p1.write_reg && (skid_p1.write_reg_addr == bus.fwd_query_addr);
        match_h = vld_p0 && head_p0.write_reg && (head_p0.write_reg_addr == bus.fwd_query_addr);
        bus.fwd_hit = match_s || match_h;
        if (match_s)      bus.fwd_data = skid_p1.write_data;
        else if (match_h) bus.fwd_data = head_p0.write_data;
        else              bus.fwd_data = '0;
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: reset, streaming, back-pressure, forwarding, flush and reset-while-full.
module tb_ex_mem_pipe;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_mem_if #(.DATA_W(16), .REG_AW(4), .OP_W(2)) bus ();

    ex_mem_pipe #(
        .DATA_W(16), .REG_AW(4), .OP_W(2), .MEM_NOP_OP(2'b00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] wd, input logic [1:0] op,
                         input logic wr, input logic [3:0] wa);
        bus.in_valid         = v;
        bus.write_data_i     = wd;
        bus.mem_op_i         = op;
        bus.mem_addr_i       = wd ^ 16'h00FF;
        bus.write_reg_i      = wr;
        bus.write_reg_addr_i = wa;
    endtask

    task automatic chk_nop(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_wdata"}, 32'(bus.write_data_o), 32'h0);
        chk({tag, "_op"}, 32'(bus.mem_op_o), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr_o), 32'h0);
        chk({tag, "_wr"}, 32'(bus.write_reg_o), 32'd0);
        chk({tag, "_wa"}, 32'(bus.write_reg_addr_o), 32'd0);
    endtask

    task automatic chk_head(input string tag, input logic [15:0] wd);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_wdata"}, 32'(bus.write_data_o), 32'(wd));
        chk({tag, "_addr"}, 32'(bus.mem_addr_o), 32'(wd ^ 16'h00FF));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.flush          = 1'b0;
        bus.out_ready      = 1'b0;
        bus.fwd_query_addr = 4'd0;
        drive(1'b0, 16'h0, 2'b00, 1'b0, 4'd0);
        step();
        step();
        rst = 1'b0;
        step();
        step();

        chk_nop("reset");
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_fwd_hit", 32'(bus.fwd_hit), 32'd0);

        bus.out_ready = 1'b1;
        drive(1'b1, 16'h1111, 2'b01, 1'b1, 4'd1);
        step();
        chk_head("s1", 16'h1111);
        chk("s1_op", 32'(bus.mem_op_o), 32'd1);
        drive(1'b1, 16'h2222, 2'b10, 1'b0, 4'd2);
        step();
        chk_head("s2", 16'h2222);
        chk("s2_op", 32'(bus.mem_op_o), 32'd2);
        drive(1'b1, 16'h3333, 2'b11, 1'b1, 4'd7);
        step();
        chk_head("s3", 16'h3333);
        chk("s3_wa", 32'(bus.write_reg_addr_o), 32'd7);
        chk("s3_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 16'h0, 2'b00, 1'b0, 4'd0);
        step();
        chk_nop("s_drain");

        bus.out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 2'b01, 1'b0, 4'd0);
        step();
        chk_head("bp_a", 16'hAAAA);
        chk("bp_a_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 16'hBBBB, 2'b01, 1'b0, 4'd0);
        step();
        chk_head("bp_full_a", 16'hAAAA);
        chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 16'hCCCC, 2'b01, 1'b0, 4'd0);
        step();
        chk_head("bp_hold_a", 16'hAAAA);
        chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        chk_head("bp_out_a", 16'hAAAA);
        step();
        chk_head("bp_out_b", 16'hBBBB);
        chk("bp_b_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk_head("bp_out_c", 16'hCCCC);
        drive(1'b0, 16'h0, 2'b00, 1'b0, 4'd0);
        step();
        chk_nop("bp_drain");

        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0005, 2'b00, 1'b1, 4'd3);
        step();
        bus.fwd_query_addr = 4'd3;
        #1;
        chk("fwd_h_only_hit", 32'(bus.fwd_hit), 32'd1);
        chk("fwd_h_only_data", 32'(bus.fwd_data), 32'h0005);
        drive(1'b1, 16'h0009, 2'b00, 1'b1, 4'd3);
        step();
        drive(1'b0, 16'h0, 2'b00, 1'b0, 4'd0);
        chk("fwd_full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fwd_q3_hit", 32'(bus.fwd_hit), 32'd1);
        chk("fwd_q3_data", 32'(bus.fwd_data), 32'h0009);
        bus.fwd_query_addr = 4'd4;
        #1;
        chk("fwd_q4_hit", 32'(bus.fwd_hit), 32'd0);
        chk("fwd_q4_data", 32'(bus.fwd_data), 32'h0);

        bus.flush = 1'b1;
        drive(1'b1, 16'hDEAD, 2'b01, 1'b1, 4'd3);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 16'h0, 2'b00, 1'b0, 4'd0);
        bus.fwd_query_addr = 4'd3;
        #1;
        chk_nop("flush_full");
        chk("flush_full_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_full_fwd", 32'(bus.fwd_hit), 32'd0);
        step();
        chk("flush_full_later", 32'(bus.out_valid), 32'd0);

        drive(1'b1, 16'h4444, 2'b01, 1'b0, 4'd0);
        step();
        chk_head("flush_one_pre", 16'h4444);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'hDEAD, 2'b01, 1'b1, 4'd3);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 16'h0, 2'b00, 1'b0, 4'd0);
        chk_nop("flush_one");
        chk("flush_one_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("flush_one_later", 32'(bus.out_valid), 32'd0);

        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0055, 2'b10, 1'b1, 4'd5);
        step();
        drive(1'b1, 16'h0066, 2'b10, 1'b1, 4'd6);
        step();
        drive(1'b0, 16'h0, 2'b00, 1'b0, 4'd0);
        chk("rst_full_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_nop("rst_full");
        chk("rst_full_in_ready_after", 32'(bus.in_ready), 32'd1);
        for (int q = 0; q < 16; q++) begin
            bus.fwd_query_addr = 4'(q);
            #1;
            chk($sformatf("rst_fwd_hit_q%0d", q), 32'(bus.fwd_hit), 32'd0);
            chk($sformatf("rst_fwd_data_q%0d", q), 32'(bus.fwd_data), 32'h0);
        end
        step();
        chk("rst_full_later", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX/MEM pipeline register. Next generation of the fixed 16-bit EX/MEM latch.
- Adds a valid/ready handshake, a 2-entry skid buffer for back-pressure, a synchronous flush, bubble (NOP) insertion, and a register-forwarding lookup.
- Sits between the EX stage (upstream) and the MEM stage (downstream). The hazard unit drives flush.

Parameters:
DATA_W, 16, width of write data and memory address
REG_AW, 4, register-file address width
OP_W, 2, memory-op field width
MEM_NOP_OP, 2'b00, memory-op value meaning "no memory access"

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  discard all held and incoming entries this edge
in_valid  in  1  EX presents an instruction
in_ready  out  1  stage can accept; registered, no combinational path from out_ready
write_data_i  in  DATA_W  ALU result / store data
mem_op_i  in  OP_W  memory operation
mem_addr_i  in  DATA_W  memory address
write_reg_i  in  1  register write-back enable
write_reg_addr_i  in  REG_AW  destination register
out_valid  out  1  head entry valid toward MEM
out_ready  in  1  MEM accepts head entry this edge
write_data_o  out  DATA_W  head entry field
mem_op_o  out  OP_W  head entry field
mem_addr_o  out  DATA_W  head entry field
write_reg_o  out  1  head entry field
write_reg_addr_o  out  REG_AW  head entry field
fwd_query_addr  in  REG_AW  source register EX wants forwarded
fwd_hit  out  1  a held entry writes fwd_query_addr
fwd_data  out  DATA_W  data of youngest matching entry

Behaviour:
- Storage: head register H (drives outputs) and skid register S.
- States: EMPTY (no entry), ONE (H valid), FULL (H and S valid).
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), registered.
- Transfers:
  - Accept = in_valid & in_ready.
  - Retire = out_valid & out_ready.
- Transitions (no flush):
  - EMPTY: accept -> H<=in, ONE. No accept -> stay EMPTY.
  - ONE:
    - retire & accept -> H<=in, stay ONE.
    - retire & !accept -> EMPTY.
    - !retire & accept -> S<=in, FULL.
    - Otherwise hold.
  - FULL: no accept is possible. retire -> H<=S, ONE. Otherwise hold.
- Latency and throughput:
  - 1 cycle from accept to out_valid.
  - Sustains 1 entry/cycle when out_ready is held high.
  - Order is strictly preserved.
- Bubble: whenever out_valid=0, the output fields are forced to a NOP:
  - write_data_o = 0, mem_op_o = MEM_NOP_OP, mem_addr_o = 0, write_reg_o = 0, write_reg_addr_o = 0.
  - This keeps a downstream stage with no handshake safe.
- Flush:
  - Next state is EMPTY and S is invalidated.
  - An incoming entry in the same cycle is discarded, even if in_valid=1.
  - Flush overrides retire and accept. out_ready during flush is ignored.
  - in_ready is 1 in the following cycle.
- Reset:
  - Same effect as flush, and also clears H and S contents to the NOP values.
  - rst has priority over flush.
  - Reset mid-back-pressure (FULL) drops both entries.
- Forwarding (combinational from stored state and fwd_query_addr):
  - Match S = S valid & S.write_reg & S.write_reg_addr == fwd_query_addr.
  - Match H = H valid & H.write_reg & H.write_reg_addr == fwd_query_addr.
  - fwd_hit = Match S | Match H.
  - fwd_data = S.write_data if Match S (S is younger, so it has priority), else H.write_data if Match H, else 0.
  - Address 0 is not special-cased; the hazard unit filters it.
- Widths: all fields pass through unmodified; no arithmetic. mem_addr uses DATA_W.

Test Plan:
- Reset, then rst=0, in_valid=0 for 2 cycles -> out_valid=0, mem_op_o=2'b00, write_reg_o=0, in_ready=1.
- Stream 3 entries (write_data 0x1111, 0x2222, 0x3333) with out_ready=1 -> each appears exactly 1 cycle after accept, in order, out_valid stays 1 for 3 consecutive cycles.
- out_ready=0; send A (write_data 0xAAAA) then B (0xBBBB) -> in_ready=0 after B accepted. C held on the input is not accepted. Raise out_ready -> outputs A, B, C in order, no loss or duplication.
- FULL with H writing r3=0x0005 and S writing r3=0x0009; query 3 -> fwd_hit=1, fwd_data=0x0009. Query 4 -> fwd_hit=0, fwd_data=0.
- FULL, then flush=1 together with in_valid=1 (write_data 0xDEAD) -> next cycle out_valid=0, in_ready=1, fields are NOP, 0xDEAD never emerges.
- rst=1 asserted while FULL and flush=0 -> next cycle EMPTY, fwd_hit=0 for every query address.
